bus_addr_router: RTL and testbench

//  Registered, parametrised successor to the combinational address decoder.
//  - Sits between one bus master and NUM_SLAVES slaves.
//  - Decodes the address against a base/size table and registers the request toward one slave.
//  - Tracks that single outstanding transaction and returns the slave response.
//  - Issues DECERR for unmapped addresses and a timeout error for a slave that never responds.

---
 rtl/bus_pkg.sv | 28 ++
 rtl/addr_region_match.sv | 49 ++++
 rtl/bus_addr_router.sv | 162 ++++++++++++++++
 tb/tb_bus_addr_router.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/bus_pkg.sv
// Shared bus constants, default slave map and router state type.
package bus_pkg;

    localparam int unsigned BUS_ADDR_WIDTH = 14;
    localparam int unsigned BUS_DATA_WIDTH = 8;

    localparam logic [13:0] SLAVE0_BASE = 14'h0000;
    localparam logic [13:0] SLAVE1_BASE = 14'h1000;
    localparam logic [13:0] SLAVE2_BASE = 14'h2000;

    localparam logic [13:0] SLAVE0_SIZE = 14'h1000;
    localparam logic [13:0] SLAVE1_SIZE = 14'h1000;
    localparam logic [13:0] SLAVE2_SIZE = 14'h0800;

    localparam int unsigned DEFAULT_TIMEOUT = 16;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        RESP   = 2'd2
    } router_state_e;

    // Index width that stays at least one bit for a single-slave build.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/addr_region_match.sv
// Combinational base/size region match; the lowest matching index wins.
module addr_region_match
    import bus_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = BUS_ADDR_WIDTH,
    parameter int unsigned NUM_SLAVES = 3,
    parameter logic [NUM_SLAVES-1:0][ADDR_WIDTH-1:0] SLAVE_BASE =
        {SLAVE2_BASE, SLAVE1_BASE, SLAVE0_BASE},
    parameter logic [NUM_SLAVES-1:0][ADDR_WIDTH-1:0] SLAVE_SIZE =
        {SLAVE2_SIZE, SLAVE1_SIZE, SLAVE0_SIZE},
    parameter int unsigned IDX_WIDTH = idx_width(NUM_SLAVES)
) (
    input  logic [ADDR_WIDTH-1:0] addr_i,
    output logic                  hit_o,
    output logic [NUM_SLAVES-1:0] sel_o,
    output logic [IDX_WIDTH-1:0]  idx_o,
    output logic [ADDR_WIDTH-1:0] local_addr_o
);

    // One extra bit so a region ending at 2^ADDR_WIDTH cannot wrap.
    logic [ADDR_WIDTH:0]  diff  [NUM_SLAVES];
    logic [NUM_SLAVES-1:0] match;

    always_comb begin
        match = '0;
        for (int i = 0; i < NUM_SLAVES; i++) begin
            diff[i]  = {1'b0, addr_i} - {1'b0, SLAVE_BASE[i]};
            match[i] = ({1'b0, addr_i} >= {1'b0, SLAVE_BASE[i]}) &&
                       (diff[i] < {1'b0, SLAVE_SIZE[i]});
        end
    end

    always_comb begin
        hit_o        = 1'b0;
        sel_o        = '0;
        idx_o        = '0;
        local_addr_o = '0;
        for (int i = NUM_SLAVES - 1; i >= 0; i--) begin
            if (match[i]) begin
                hit_o        = 1'b1;
                sel_o        = '0;
                sel_o[i]     = 1'b1;
                idx_o        = IDX_WIDTH'(i);
                local_addr_o = diff[i][ADDR_WIDTH-1:0];
            end
        end
    end

endmodule

// File: rtl/bus_addr_router.sv
// Registered single-outstanding bus router with decode error and slave timeout.
module bus_addr_router
    import bus_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = BUS_ADDR_WIDTH,
    parameter int unsigned DATA_WIDTH = BUS_DATA_WIDTH,
    parameter int unsigned NUM_SLAVES = 3,
    parameter logic [NUM_SLAVES-1:0][ADDR_WIDTH-1:0] SLAVE_BASE =
        {SLAVE2_BASE, SLAVE1_BASE, SLAVE0_BASE},
    parameter logic [NUM_SLAVES-1:0][ADDR_WIDTH-1:0] SLAVE_SIZE =
        {SLAVE2_SIZE, SLAVE1_SIZE, SLAVE0_SIZE},
    parameter int unsigned TIMEOUT_CYCLES = DEFAULT_TIMEOUT
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  valid_i,
    input  logic [ADDR_WIDTH-1:0] addr_i,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    input  logic                  we_i,
    output logic                  ready_o,
    output logic [DATA_WIDTH-1:0] rdata_o,
    output logic                  err_o,
    output logic [NUM_SLAVES-1:0] slave_sel_o,
    output logic [NUM_SLAVES-1:0] slave_valid_o,
    output logic [ADDR_WIDTH-1:0] slave_addr_o,
    output logic [DATA_WIDTH-1:0] slave_wdata_o,
    output logic                  slave_we_o,
    input  logic [NUM_SLAVES-1:0] slave_ready_i,
    input  logic [DATA_WIDTH-1:0] slave_rdata_i [NUM_SLAVES],
    input  logic [NUM_SLAVES-1:0] slave_err_i,
    output logic                  busy_o,
    output logic                  timeout_o
);

    localparam int unsigned IdxW = idx_width(NUM_SLAVES);
    localparam int unsigned CntW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam bit          TimeoutEn = (TIMEOUT_CYCLES > 0);
    localparam logic [CntW-1:0] CntLast = CntW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

    logic                  m_hit;
    logic [NUM_SLAVES-1:0] m_sel;
    logic [IdxW-1:0]       m_idx;
    logic [ADDR_WIDTH-1:0] m_local;

    router_state_e         state_q, state_d;
    logic [NUM_SLAVES-1:0] sel_q, sel_d;
    logic [IdxW-1:0]       idx_q, idx_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic                  we_q, we_d;
    logic [CntW-1:0]       cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic                  err_q, err_d;
    logic                  to_q, to_d;

    addr_region_match #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .NUM_SLAVES (NUM_SLAVES),
        .SLAVE_BASE (SLAVE_BASE),
        .SLAVE_SIZE (SLAVE_SIZE),
        .IDX_WIDTH  (IdxW)
    ) u_match (
        .addr_i       (addr_i),
        .hit_o        (m_hit),
        .sel_o        (m_sel),
        .idx_o        (m_idx),
        .local_addr_o (m_local)
    );

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        idx_d   = idx_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        we_d    = we_q;
        cnt_d   = cnt_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        to_d    = to_q;
        unique case (state_q)
            IDLE: begin
                if (valid_i) begin
                    if (m_hit) begin
                        state_d = ACTIVE;
                        sel_d   = m_sel;
                        idx_d   = m_idx;
                        addr_d  = m_local;
                        wdata_d = wdata_i;
                        we_d    = we_i;
                        cnt_d   = '0;
                    end else begin
                        state_d = RESP;
                        rdata_d = '0;
                        err_d   = 1'b1;
                        to_d    = 1'b0;
                    end
                end
            end
            ACTIVE: begin
                // A ready on the final allowed cycle beats the timeout.
                if (slave_ready_i[idx_q]) begin
                    state_d = RESP;
                    rdata_d = slave_rdata_i[idx_q];
                    err_d   = slave_err_i[idx_q];
                    to_d    = 1'b0;
                end else if (TimeoutEn && (cnt_q == CntLast)) begin
                    state_d = RESP;
                    rdata_d = '0;
                    err_d   = 1'b1;
                    to_d    = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            RESP: begin
                state_d = IDLE;
                sel_d   = '0;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            sel_q   <= '0;
            idx_q   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            we_q    <= 1'b0;
            cnt_q   <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
            to_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            idx_q   <= idx_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            we_q    <= we_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
            to_q    <= to_d;
        end
    end

    // Response fields are only presented during the single RESP cycle.
    assign ready_o       = (state_q == RESP);
    assign rdata_o       = ready_o ? rdata_q : '0;
    assign err_o         = ready_o & err_q;
    assign timeout_o     = ready_o & to_q;
    assign busy_o        = (state_q != IDLE);
    assign slave_sel_o   = sel_q;
    assign slave_valid_o = (state_q == ACTIVE) ? sel_q : '0;
    assign slave_addr_o  = addr_q;
    assign slave_wdata_o = wdata_q;
    assign slave_we_o    = we_q;

endmodule

// File: tb/tb_bus_addr_router.sv
// Scoreboard bench: default 3-slave router plus a 4-slave overlapping-map build.
module tb_bus_addr_router;

    typedef struct packed {
        logic [7:0] rdata;
        logic       err;
        logic       to;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    exp_t sb_q[$];
    exp_t sb2_q[$];

    // Default build
    logic        valid_i = 1'b0;
    logic [13:0] addr_i = '0;
    logic [7:0]  wdata_i = '0;
    logic        we_i = 1'b0;
    logic        ready_o, err_o, slave_we_o, busy_o, timeout_o;
    logic [7:0]  rdata_o, slave_wdata_o;
    logic [2:0]  slave_sel_o, slave_valid_o;
    logic [13:0] slave_addr_o;
    logic [2:0]  s_rdy = '0;
    logic [2:0]  s_err = '0;
    logic [7:0]  s_rd [3];

    bus_addr_router u_dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .valid_i       (valid_i),
        .addr_i        (addr_i),
        .wdata_i       (wdata_i),
        .we_i          (we_i),
        .ready_o       (ready_o),
        .rdata_o       (rdata_o),
        .err_o         (err_o),
        .slave_sel_o   (slave_sel_o),
        .slave_valid_o (slave_valid_o),
        .slave_addr_o  (slave_addr_o),
        .slave_wdata_o (slave_wdata_o),
        .slave_we_o    (slave_we_o),
        .slave_ready_i (s_rdy),
        .slave_rdata_i (s_rd),
        .slave_err_i   (s_err),
        .busy_o        (busy_o),
        .timeout_o     (timeout_o)
    );

    // Overlapping map: s0 0x3000+0x1000, s1 0x3800+0x800, s2 0x1000+0x1000, s3 0x0000+0x3000
    logic        v2 = 1'b0;
    logic [13:0] a2 = '0;
    logic        ready2, err2, we2_o, busy2, to2;
    logic [7:0]  rdata2, wdata2_o;
    logic [3:0]  sel2, valid2;
    logic [13:0] addr2_o;
    logic [3:0]  s2_rdy = '0;
    logic [7:0]  s2_rd [4];

    bus_addr_router #(
        .NUM_SLAVES (4),
        .SLAVE_BASE ({14'h0000, 14'h1000, 14'h3800, 14'h3000}),
        .SLAVE_SIZE ({14'h3000, 14'h1000, 14'h0800, 14'h1000})
    ) u_dut4 (
        .clk           (clk),
        .rst_n         (rst_n),
        .valid_i       (v2),
        .addr_i        (a2),
        .wdata_i       (8'h00),
        .we_i          (1'b0),
        .ready_o       (ready2),
        .rdata_o       (rdata2),
        .err_o         (err2),
        .slave_sel_o   (sel2),
        .slave_valid_o (valid2),
        .slave_addr_o  (addr2_o),
        .slave_wdata_o (wdata2_o),
        .slave_we_o    (we2_o),
        .slave_ready_i (s2_rdy),
        .slave_rdata_i (s2_rd),
        .slave_err_i   (4'b0000),
        .busy_o        (busy2),
        .timeout_o     (to2)
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && ready_o) begin
            if (sb_q.size() == 0) begin
                check_eq("spurious_ready", 1, 0);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                check_eq("rsp.rdata", rdata_o, e.rdata);
                check_eq("rsp.err", err_o, e.err);
                check_eq("rsp.timeout", timeout_o, e.to);
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n && ready2) begin
            if (sb2_q.size() == 0) begin
                check_eq("spurious_ready4", 1, 0);
            end else begin
                exp_t e;
                e = sb2_q.pop_front();
                check_eq("rsp4.rdata", rdata2, e.rdata);
                check_eq("rsp4.err", err2, e.err);
            end
        end
    end

    // idx < 0 means unmapped; dly < 0 means the slave never answers.
    task automatic run_txn(input string nm, input logic [13:0] a, input logic [7:0] wd,
                           input logic w, input int idx, input logic [13:0] exp_local,
                           input int dly, input logic [7:0] rd, input logic se);
        exp_t       e;
        int         exp_vc, vcyc, cycles;
        logic       done;
        logic [2:0] oh;
        oh = '0;
        if (idx < 0) begin
            e = '{rdata: 8'h00, err: 1'b1, to: 1'b0};
            exp_vc = 0;
        end else if (dly < 0) begin
            e = '{rdata: 8'h00, err: 1'b1, to: 1'b1};
            exp_vc = 16;
            oh[idx] = 1'b1;
        end else begin
            e = '{rdata: rd, err: se, to: 1'b0};
            exp_vc = dly + 1;
            oh[idx] = 1'b1;
        end
        @(negedge clk);
        valid_i = 1'b1;
        addr_i  = a;
        wdata_i = wd;
        we_i    = w;
        sb_q.push_back(e);
        vcyc = 0;
        cycles = 0;
        done = 1'b0;
        while (!done && cycles < 64) begin
            @(negedge clk);
            cycles++;
            if (ready_o) begin
                done = 1'b1;
            end else if (slave_valid_o != 3'b000) begin
                if (vcyc == 0) begin
                    check_eq({nm, ".valid"}, slave_valid_o, oh);
                    check_eq({nm, ".sel"}, slave_sel_o, oh);
                    check_eq({nm, ".laddr"}, slave_addr_o, exp_local);
                    check_eq({nm, ".we"}, slave_we_o, w);
                    check_eq({nm, ".wdata"}, slave_wdata_o, wd);
                end
                if (idx >= 0 && vcyc == dly) begin
                    s_rdy[idx] = 1'b1;
                    s_rd[idx]  = rd;
                    s_err[idx] = se;
                end
                vcyc++;
            end
        end
        valid_i = 1'b0;
        s_rdy   = '0;
        s_err   = '0;
        check_eq({nm, ".done"}, done, 1'b1);
        check_eq({nm, ".valid_cycles"}, vcyc, exp_vc);
        check_eq({nm, ".latency"}, cycles, exp_vc + 1);
        check_eq({nm, ".sel_resp"}, slave_sel_o, oh);
        @(negedge clk);
        check_eq({nm, ".busy_after"}, busy_o, 1'b0);
        check_eq({nm, ".sel_idle"}, slave_sel_o, 3'b000);
        if (idx >= 0) check_eq({nm, ".laddr_hold"}, slave_addr_o, exp_local);
    endtask

    task automatic run4(input string nm, input logic [13:0] a, input int idx,
                        input logic [13:0] exp_local, input logic [7:0] rd);
        logic [3:0] oh;
        int         cycles;
        oh = '0;
        oh[idx] = 1'b1;
        @(negedge clk);
        v2 = 1'b1;
        a2 = a;
        sb2_q.push_back('{rdata: rd, err: 1'b0, to: 1'b0});
        @(negedge clk);
        check_eq({nm, ".valid"}, valid2, oh);
        check_eq({nm, ".laddr"}, addr2_o, exp_local);
        s2_rdy[idx] = 1'b1;
        s2_rd[idx]  = rd;
        cycles = 0;
        while (!ready2 && cycles < 8) begin
            @(negedge clk);
            cycles++;
        end
        check_eq({nm, ".done"}, ready2, 1'b1);
        v2 = 1'b0;
        s2_rdy = '0;
        @(negedge clk);
    endtask

    initial begin
        int rdy_seen;
        for (int i = 0; i < 3; i++) s_rd[i] = 8'hA0 + 8'(i);
        for (int i = 0; i < 4; i++) s2_rd[i] = 8'h00;
        #12;
        check_eq("reset.outputs",
                 {ready_o, rdata_o, err_o, slave_sel_o, slave_valid_o, slave_addr_o,
                  slave_wdata_o, slave_we_o, busy_o, timeout_o}, 0);
        check_eq("reset.outputs4", {ready2, sel2, valid2, addr2_o, busy2, to2}, 0);
        @(negedge clk);
        rst_n = 1'b1;

        run_txn("t1_write", 14'h1FFF, 8'h42, 1'b1, 1, 14'h0FFF, 2, 8'h5A, 1'b0);
        run_txn("t2_read", 14'h2100, 8'h00, 1'b0, 2, 14'h0100, 3, 8'hEF, 1'b0);
        run_txn("t3_miss_a", 14'h2800, 8'h11, 1'b0, -1, 14'h0000, 0, 8'h00, 1'b0);
        run_txn("t3_miss_b", 14'h3FFF, 8'h22, 1'b0, -1, 14'h0000, 0, 8'h00, 1'b0);
        // Unselected slave asserting ready/err must not end the timeout transaction.
        s_rdy[1] = 1'b1;
        s_err[1] = 1'b1;
        run_txn("t4_timeout", 14'h0500, 8'h00, 1'b0, 0, 14'h0500, -1, 8'h00, 1'b0);
        run_txn("t5_slverr", 14'h1800, 8'h00, 1'b0, 1, 14'h0800, 1, 8'h33, 1'b1);
        run_txn("t5_lastcyc", 14'h0FFF, 8'h00, 1'b0, 0, 14'h0FFF, 15, 8'h77, 1'b0);
        run_txn("t_base1", 14'h1000, 8'h99, 1'b1, 1, 14'h0000, 0, 8'h00, 1'b0);

        // Abort mid-transaction with an asynchronous reset.
        @(negedge clk);
        valid_i = 1'b1;
        addr_i  = 14'h0500;
        repeat (3) @(negedge clk);
        check_eq("t6.active_before_rst", slave_valid_o, 3'b001);
        #2 rst_n = 1'b0;
        valid_i = 1'b0;
        #1;
        check_eq("t6.async_outputs",
                 {ready_o, rdata_o, err_o, slave_sel_o, slave_valid_o, slave_addr_o,
                  slave_wdata_o, slave_we_o, busy_o, timeout_o}, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        rdy_seen = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (ready_o) rdy_seen++;
        end
        check_eq("t6.no_ready", rdy_seen, 0);
        check_eq("t6.busy", busy_o, 1'b0);

        run4("t7_s0_top", 14'h3FFF, 0, 14'h0FFF, 8'h10);
        run4("t7_s0_ovl", 14'h3900, 0, 14'h0900, 8'h20);
        run4("t7_s2_ovl", 14'h1100, 2, 14'h0100, 8'h30);
        run4("t7_s3", 14'h0100, 3, 14'h0100, 8'h40);

        repeat (3) @(negedge clk);
        check_eq("scoreboard_empty", sb_q.size() + sb2_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog");
    end

endmodule
